// File: rtl/conv_tx_pkg.sv
// Shared types and code constants for the framed K=3, rate-1/2 convolutional transmitter.
// The generator taps are ordered {d, s1, s2}; conv_symbol returns {G0 bit, G1 bit}.
package conv_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_TAIL = 2'd2
  } conv_state_e;

  localparam int K = 3;
  localparam logic [K-1:0] G0 = 3'b111;
  localparam logic [K-1:0] G1 = 3'b101;
  localparam int TAIL_LEN = 2;

  function automatic logic [1:0] conv_symbol(input logic d, input logic [K-2:0] s);
    logic [K-1:0] taps;
    taps = {d, s};
    return {^(taps & G0), ^(taps & G1)};
  endfunction

endpackage

// File: rtl/conv_enc_core.sv
// Encoder shift register {s1,s2} plus generator XORs; the symbol is combinational in d.
// clear has priority over advance, and both act on the next clock edge.
module conv_enc_core
  import conv_tx_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       d,
  input  logic       advance,
  input  logic       clear,
  output logic [1:0] sym
);

  // shreg[K-2] is s1 (the most recent bit), shreg[0] is s2.
  logic [K-2:0] shreg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg <= '0;
    end else if (clear) begin
      shreg <= '0;
    end else if (advance) begin
      shreg <= {d, shreg[K-2:1]};
    end
  end

  assign sym = conv_symbol(d, shreg);

endmodule

// File: rtl/conv_frame_tx.sv
// Framed convolutional transmitter: IDLE -> DATA (FRAME_LEN payload bits) -> optional TAIL flush.
// Optional tail flush is built in when the macro CONV_TX_TAIL_EN is defined.
module conv_frame_tx
  import conv_tx_pkg::*;
#(
  parameter int FRAME_LEN = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        enable_i,
  input  logic        d_in,
  output logic        ready_o,
  output logic        valid_o,
  output logic [1:0]  d_out,
  output logic        busy_o,
  output logic        frame_done_o,
  output conv_state_e state_dbg
);

  localparam logic [15:0] LAST_IDX = 16'(FRAME_LEN - 1);

  conv_state_e state, state_nxt;
  logic [15:0] bit_cnt, bit_cnt_nxt;
  logic        enc_adv, enc_clr, enc_d, done_nxt;
  logic [1:0]  sym;

`ifdef CONV_TX_TAIL_EN
  localparam int TW = (TAIL_LEN > 1) ? $clog2(TAIL_LEN) : 1;
  localparam logic [TW-1:0] LAST_TAIL = TW'(TAIL_LEN - 1);
  logic [TW-1:0] tail_idx, tail_idx_nxt;
`endif

  // Handshake: a payload bit transfers on a rising edge where enable_i && ready_o;
  // its symbol appears on d_out with valid_o one cycle later, with no backpressure on the output.
  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    done_nxt    = 1'b0;
    enc_adv     = 1'b0;
    enc_clr     = 1'b0;
    enc_d       = d_in;
`ifdef CONV_TX_TAIL_EN
    tail_idx_nxt = tail_idx;
`endif
    case (state)
      ST_IDLE: begin
        if (start_i) begin
          state_nxt   = ST_DATA;
          bit_cnt_nxt = '0;
          enc_clr     = 1'b1;
        end
      end
      ST_DATA: begin
        if (enable_i) begin
          enc_adv     = 1'b1;
          bit_cnt_nxt = bit_cnt + 16'd1;
          if (bit_cnt == LAST_IDX) begin
`ifdef CONV_TX_TAIL_EN
            state_nxt    = ST_TAIL;
            tail_idx_nxt = '0;
`else
            state_nxt = ST_IDLE;
            done_nxt  = 1'b1;
`endif
          end
        end
      end
      ST_TAIL: begin
`ifdef CONV_TX_TAIL_EN
        // Flush zeros so the trellis terminates in state 00.
        enc_adv      = 1'b1;
        enc_d        = 1'b0;
        tail_idx_nxt = tail_idx + TW'(1);
        if (tail_idx == LAST_TAIL) begin
          state_nxt = ST_IDLE;
          done_nxt  = 1'b1;
        end
`else
        state_nxt = ST_IDLE;
`endif
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_IDLE;
      bit_cnt      <= '0;
      valid_o      <= 1'b0;
      d_out        <= 2'b00;
      frame_done_o <= 1'b0;
    end else begin
      state        <= state_nxt;
      bit_cnt      <= bit_cnt_nxt;
      valid_o      <= enc_adv;
      d_out        <= enc_adv ? sym : 2'b00;
      frame_done_o <= done_nxt;
    end
  end

`ifdef CONV_TX_TAIL_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tail_idx <= '0;
    end else begin
      tail_idx <= tail_idx_nxt;
    end
  end
`endif

  conv_enc_core u_enc (
    .clk     (clk),
    .rst     (rst),
    .d       (enc_d),
    .advance (enc_adv),
    .clear   (enc_clr),
    .sym     (sym)
  );

  assign ready_o   = (state == ST_DATA);
  assign busy_o    = (state != ST_IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_conv_frame_tx.sv
// Bench for conv_frame_tx: instance 0 has FRAME_LEN=4, instance 1 has FRAME_LEN=1.
// Expected outputs come from a frame-level reference model and from fixed vector tables.
module tb_conv_frame_tx;
  import conv_tx_pkg::*;

`ifdef CONV_TX_TAIL_EN
  localparam bit TAIL_EN = 1'b1;
`else
  localparam bit TAIL_EN = 1'b0;
`endif

  typedef struct packed {
    logic       ready;
    logic       busy;
    logic       valid;
    logic       done;
    logic [1:0] d_out;
  } obs_t;

  typedef struct {
    bit   st;
    bit   en;
    bit   d;
    obs_t exp;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic st0 = 1'b0, en0 = 1'b0, d0 = 1'b0;
  logic st1 = 1'b0, en1 = 1'b0, d1 = 1'b0;
  logic ready0, valid0, busy0, done0, ready1, valid1, busy1, done1;
  logic [1:0] dout0, dout1;
  conv_state_e dbg0, dbg1;
  obs_t obs0, obs1;

  assign obs0 = {ready0, busy0, valid0, done0, dout0};
  assign obs1 = {ready1, busy1, valid1, done1, dout1};

  conv_frame_tx #(.FRAME_LEN(4)) dut (
    .clk(clk), .rst(rst), .start_i(st0), .enable_i(en0), .d_in(d0),
    .ready_o(ready0), .valid_o(valid0), .d_out(dout0), .busy_o(busy0),
    .frame_done_o(done0), .state_dbg(dbg0)
  );

  conv_frame_tx #(.FRAME_LEN(1)) dut1 (
    .clk(clk), .rst(rst), .start_i(st1), .enable_i(en1), .d_in(d1),
    .ready_o(ready1), .valid_o(valid1), .d_out(dout1), .busy_o(busy1),
    .frame_done_o(done1), .state_dbg(dbg1)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [5:0] exp_q[$];
  logic [1:0] sym0_q[$];
  logic [1:0] sym1_q[$];
  int done0_cnt = 0;
  int done1_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Per instance: phase 0 = no frame, 1 = taking payload, 2 = flushing.
  int m_phase[2];
  int m_cnt[2];
  int m_tail_left[2];
  bit m_p1[2];
  bit m_p2[2];

  function automatic obs_t model_step(input int i, input bit st, input bit en, input bit d,
                                      input int flen);
    obs_t o;
    o = '0;
    if (m_phase[i] == 0) begin
      if (st) begin
        m_phase[i] = 1;
        m_cnt[i]   = 0;
        m_p1[i]    = 1'b0;
        m_p2[i]    = 1'b0;
      end
    end else if (m_phase[i] == 1) begin
      if (en) begin
        o.valid = 1'b1;
        o.d_out = {d ^ m_p1[i] ^ m_p2[i], d ^ m_p2[i]};
        m_p2[i] = m_p1[i];
        m_p1[i] = d;
        m_cnt[i]++;
        if (m_cnt[i] == flen) begin
          if (TAIL_EN) begin
            m_phase[i]     = 2;
            m_tail_left[i] = 2;
          end else begin
            m_phase[i] = 0;
            o.done     = 1'b1;
          end
        end
      end
    end else begin
      o.valid = 1'b1;
      o.d_out = {m_p1[i] ^ m_p2[i], m_p2[i]};
      m_p2[i] = m_p1[i];
      m_p1[i] = 1'b0;
      m_tail_left[i]--;
      if (m_tail_left[i] == 0) begin
        m_phase[i] = 0;
        o.done     = 1'b1;
      end
    end
    o.ready = (m_phase[i] == 1);
    o.busy  = (m_phase[i] != 0);
    return o;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_phase[i] = 0;
      m_cnt[i] = 0;
      m_tail_left[i] = 0;
      m_p1[i] = 1'b0;
      m_p2[i] = 1'b0;
    end
  endtask

  // ---------------- driver ----------------
  // Called #1 after a rising edge; drives one instance, idles the other, checks both.
  task automatic step(input int i, input bit st, input bit en, input bit d);
    obs_t e0, e1;
    if (i == 0) begin
      st0 = st; en0 = en; d0 = d; st1 = 1'b0; en1 = 1'b0; d1 = 1'b0;
      e0 = model_step(0, st, en, d, 4);
      e1 = model_step(1, 1'b0, 1'b0, 1'b0, 1);
    end else begin
      st1 = st; en1 = en; d1 = d; st0 = 1'b0; en0 = 1'b0; d0 = 1'b0;
      e0 = model_step(0, 1'b0, 1'b0, 1'b0, 4);
      e1 = model_step(1, st, en, d, 1);
    end
    exp_q.push_back(e0);
    exp_q.push_back(e1);
    @(posedge clk);
    #1;
    check("model_inst0", 32'(obs0), 32'(exp_q.pop_front()));
    check("model_inst1", 32'(obs1), 32'(exp_q.pop_front()));
    if (valid0) sym0_q.push_back(dout0);
    if (valid1) sym1_q.push_back(dout1);
    if (done0) done0_cnt++;
    if (done1) done1_cnt++;
  endtask

  vec_t tbl[8];

  task automatic run_table(input string tag);
    for (int k = 0; k < 8; k++) begin
      step(0, tbl[k].st, tbl[k].en, tbl[k].d);
      check($sformatf("%s_row%0d", tag, k), 32'(obs0), 32'(tbl[k].exp));
    end
  endtask

  task automatic check_syms0(input string tag);
    logic [1:0] ref_q[$];
    ref_q = TAIL_EN ? '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11}
                    : '{2'b11, 2'b10, 2'b00, 2'b01};
    check({tag, "_count"}, 32'(sym0_q.size()), 32'(ref_q.size()));
    for (int k = 0; k < ref_q.size() && k < sym0_q.size(); k++)
      check($sformatf("%s_sym%0d", tag, k), 32'(sym0_q[k]), 32'(ref_q[k]));
    check({tag, "_done"}, 32'(done0_cnt), 32'd1);
  endtask

  initial begin
    logic [1:0] ref1_q[$];
    int cyc;

    // Vector table for bits 1,0,1,1 on the FRAME_LEN=4 instance.
    tbl[0] = '{1'b1, 1'b1, 1'b1, obs_t'({1'b1, 1'b1, 1'b0, 1'b0, 2'b00})};
    tbl[1] = '{1'b0, 1'b1, 1'b1, obs_t'({1'b1, 1'b1, 1'b1, 1'b0, 2'b11})};
    tbl[2] = '{1'b0, 1'b1, 1'b0, obs_t'({1'b1, 1'b1, 1'b1, 1'b0, 2'b10})};
    tbl[3] = '{1'b0, 1'b1, 1'b1, obs_t'({1'b1, 1'b1, 1'b1, 1'b0, 2'b00})};
`ifdef CONV_TX_TAIL_EN
    tbl[4] = '{1'b0, 1'b1, 1'b1, obs_t'({1'b0, 1'b1, 1'b1, 1'b0, 2'b01})};
    tbl[5] = '{1'b0, 1'b1, 1'b1, obs_t'({1'b0, 1'b1, 1'b1, 1'b0, 2'b01})};
    tbl[6] = '{1'b0, 1'b0, 1'b0, obs_t'({1'b0, 1'b0, 1'b1, 1'b1, 2'b11})};
`else
    tbl[4] = '{1'b0, 1'b1, 1'b1, obs_t'({1'b0, 1'b0, 1'b1, 1'b1, 2'b01})};
    tbl[5] = '{1'b0, 1'b1, 1'b1, obs_t'({1'b0, 1'b0, 1'b0, 1'b0, 2'b00})};
    tbl[6] = '{1'b0, 1'b0, 1'b0, obs_t'({1'b0, 1'b0, 1'b0, 1'b0, 2'b00})};
`endif
    tbl[7] = '{1'b0, 1'b0, 1'b0, obs_t'({1'b0, 1'b0, 1'b0, 1'b0, 2'b00})};

    model_reset();

    // Reset state
    #12;
    check("reset_inst0", 32'(obs0), 32'd0);
    check("reset_inst1", 32'(obs1), 32'd0);
    check("reset_state", 32'(dbg0), 32'(ST_IDLE));
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Basic frame from the vector table
    sym0_q.delete(); done0_cnt = 0;
    run_table("basic");
    check_syms0("basic");

    // Enable gaps during payload
    sym0_q.delete(); done0_cnt = 0;
    step(0, 1'b1, 1'b0, 1'b0);
    step(0, 1'b0, 1'b1, 1'b1);
    step(0, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
    step(0, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
    step(0, 1'b0, 1'b1, 1'b0);
    step(0, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
    step(0, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
    step(0, 1'b0, 1'b1, 1'b1);
    step(0, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
    step(0, 1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) step(0, 1'b0, 1'b0, 1'b0);
    check_syms0("gaps");

    // start_i pulses during payload, enable_i during flush/idle
    sym0_q.delete(); done0_cnt = 0;
    step(0, 1'b1, 1'b0, 1'b0);
    step(0, 1'b1, 1'b1, 1'b1);
    step(0, 1'b1, 1'b0, 1'b1);
    step(0, 1'b1, 1'b1, 1'b0);
    step(0, 1'b1, 1'b1, 1'b1);
    step(0, 1'b1, 1'b1, 1'b1);
    step(0, 1'b0, 1'b1, 1'b1);
    step(0, 1'b0, 1'b1, 1'b1);
    step(0, 1'b0, 1'b1, 1'b0);
    check_syms0("pulses");

    // Asynchronous reset mid-frame, then a clean frame
    sym0_q.delete(); done0_cnt = 0;
    step(0, 1'b1, 1'b0, 1'b0);
    step(0, 1'b0, 1'b1, 1'b1);
    step(0, 1'b0, 1'b1, 1'b0);
    rst = 1'b0;
    #1;
    check("async_rst_inst0", 32'(obs0), 32'd0);
    check("async_rst_state", 32'(dbg0), 32'(ST_IDLE));
    en0 = 1'b1; d0 = 1'b1;
    @(posedge clk);
    #1;
    check("held_rst_inst0", 32'(obs0), 32'd0);
    check("held_rst_inst1", 32'(obs1), 32'd0);
    rst = 1'b1;
    model_reset();
    step(0, 1'b0, 1'b0, 1'b0);
    check("no_done_after_rst", 32'(done0_cnt), 32'd0);
    sym0_q.delete();
    run_table("post_rst");
    check_syms0("post_rst");

    // Back-to-back FRAME_LEN=1 frames of bit 1
    sym1_q.delete(); done1_cnt = 0;
    for (int f = 0; f < 2; f++) begin
      step(1, 1'b1, 1'b0, 1'b0);
      step(1, 1'b0, 1'b1, 1'b1);
      cyc = 0;
      while (m_phase[1] != 0 && cyc < 10) begin
        step(1, 1'b0, 1'b0, 1'b0);
        cyc++;
      end
    end
    step(1, 1'b0, 1'b0, 1'b0);
    ref1_q = TAIL_EN ? '{2'b11, 2'b10, 2'b11, 2'b11, 2'b10, 2'b11} : '{2'b11, 2'b11};
    check("b2b_count", 32'(sym1_q.size()), 32'(ref1_q.size()));
    for (int k = 0; k < ref1_q.size() && k < sym1_q.size(); k++)
      check($sformatf("b2b_sym%0d", k), 32'(sym1_q[k]), 32'(ref1_q[k]));
    check("b2b_done", 32'(done1_cnt), 32'd2);

    // Randomized frames against the model
    for (int f = 0; f < 25; f++) begin
      step(0, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      cyc = 0;
      while (m_phase[0] != 0 && cyc < 200) begin
        step(0, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
             1'($urandom_range(0, 1)));
        cyc++;
      end
      for (int g = $urandom_range(0, 3); g > 0; g--)
        step(0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_frame_tx.md
CONV_FRAME_TX -- requirements
Module: conv_frame_tx

Interface
REQ-001 Parameter FRAME_LEN, default 64: number of payload bits per frame, legal range 1..65535.
REQ-002 clk  input  1  single clock, all state updates on posedge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 start_i  input  1  request to open a new frame; sampled only in IDLE.
REQ-005 enable_i  input  1  d_in holds a valid payload bit this cycle.
REQ-006 d_in  input  1  payload bit.
REQ-007 ready_o  output  1  high only in DATA; a bit is accepted when enable_i && ready_o.
REQ-008 valid_o  output  2-bit symbol on d_out is valid this cycle (1 bit).
REQ-009 d_out  output  2  rate-1/2 code symbol {g0 bit, g1 bit}.
REQ-010 busy_o  output  1  high in DATA or TAIL.
REQ-011 frame_done_o  output  1  one-cycle pulse on the last symbol of a frame.

Function
REQ-012 Code: K=3, encoder state {s1,s2}, s1 = most recent bit; d_out[1] = d^s1^s2 (G0=111), d_out[0] = d^s2 (G1=101).
REQ-013 After each encoded bit: s2 <= s1, s1 <= d.
REQ-014 Latency: symbol for a bit accepted in cycle n is on d_out with valid_o=1 in cycle n+1; d_out/valid_o registered.
REQ-015 valid_o=0 in any cycle following no accept and no tail bit; d_out then holds 2'b00.
REQ-016 FSM states IDLE, DATA, TAIL.
REQ-017 IDLE: ready_o=0, busy_o=0; start_i=1 -> DATA, bit counter cleared, {s1,s2} cleared.
REQ-018 DATA: each accept increments the bit counter; accept of bit FRAME_LEN-1 (0-based) -> TAIL (or IDLE, see REQ-026).
REQ-019 DATA with enable_i=0: hold state, counter and encoder state; no symbol produced.
REQ-020 TAIL: two cycles, each encoding d=0 regardless of enable_i/d_in; ready_o=0; then -> IDLE.
REQ-021 frame_done_o is asserted in the same cycle as valid_o for the final tail symbol.
REQ-022 start_i outside IDLE ignored; enable_i outside DATA ignored; enable_i in the cycle start_i is taken in IDLE ignored.
REQ-023 Back-to-back: start_i in the cycle after returning to IDLE opens the next frame; encoder state begins at 00.

Reset
REQ-024 rst=0 asynchronously forces IDLE, counter 0, {s1,s2}=00, ready_o=0, valid_o=0, d_out=00, busy_o=0, frame_done_o=0.
REQ-025 Reset mid-frame discards the frame; no frame_done_o is produced for it.

Configuration
REQ-026 Macro CONV_TX_TAIL_EN: defined -> TAIL state and 2 flush symbols per frame (2*FRAME_LEN+4 coded bits); undefined -> no TAIL state, last payload accept returns to IDLE, frame_done_o accompanies the last payload symbol, encoder state cleared only at start.

Structure
REQ-027 Package conv_tx_pkg holds the state enum, K=3, G0=3'b111, G1=3'b101, TAIL_LEN=2.
REQ-028 One sub-module conv_enc_core: encoder state register plus generator XORs, inputs bit/advance/clear, output 2-bit symbol.

Verification
REQ-029 FRAME_LEN=4, TAIL_EN, bits 1,0,1,1 with enable_i each cycle -> d_out 11,10,00,01 then tail 01,11; frame_done_o with the 11 tail symbol.
REQ-030 Same stimulus, macro undefined -> d_out 11,10,00,01; frame_done_o with 01; no tail symbols.
REQ-031 enable_i gaps (1,0,0,1 pattern) during DATA -> symbols identical to REQ-029 values, each one cycle after its accept, valid_o=0 in gaps.
REQ-032 start_i and enable_i pulsed during DATA/TAIL -> no restart, no extra symbols, counter unaffected.
REQ-033 rst asserted after 2 of 4 bits, then new frame 1,0,1,1 -> all outputs 0 during reset, new frame reproduces REQ-029 sequence exactly.
REQ-034 FRAME_LEN=1, two back-to-back frames of bit 1 -> each frame 11,10,11; frame_done_o pulses twice.
